vc_arbiter: RTL and testbench

VC_ARBITER -- requirements
Module: vc_arbiter

---
 rtl/vc_arbiter.sv | 122 ++++++++++++
 tb/tb_vc_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter.sv
// Two-VC arbiter feeding two destination FIFOs. VC0 has priority; a
// programmable starvation guard hands every (threshold+1)-th grant to VC1
// while VC1 keeps waiting. The popped word is registered and pushed to the
// destination FIFO one cycle after the pop.
module vc_arbiter #(
    parameter int data_width = 6,
    parameter int dest_bit   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [3:0]            umbral_starve,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [data_width-1:0] vc0_data,
    input  logic [data_width-1:0] vc1_data,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    output logic                  vc0_pop,
    output logic                  vc1_pop,
    output logic                  d0_push,
    output logic                  d1_push,
    output logic [data_width-1:0] data_out,
    output logic [1:0]            state_out
);

    typedef enum logic [1:0] {
        S_RESET  = 2'b00,
        S_INIT   = 2'b01,
        S_IDLE   = 2'b10,
        S_ACTIVE = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            thr_q, thr_d;
    logic [3:0]            starve_q, starve_d;
    logic                  d0_push_q, d0_push_d;
    logic                  d1_push_q, d1_push_d;
    logic [data_width-1:0] data_out_q, data_out_d;

    logic elig0, elig1, serving, guard, grant0, grant1;

    // Eligibility: head present and its destination FIFO has room.
    always_comb begin
        elig0   = !vc0_empty && !(vc0_data[dest_bit] ? d1_almost_full : d0_almost_full);
        elig1   = !vc1_empty && !(vc1_data[dest_bit] ? d1_almost_full : d0_almost_full);
        serving = (state_q == S_IDLE) || (state_q == S_ACTIVE);
        guard   = (thr_q != 4'd0) && (starve_q == thr_q) && elig1;
        grant1  = serving && elig1 && (!elig0 || guard);
        grant0  = serving && elig0 && !grant1;
    end

    // Next-state logic; threshold is captured only on the INIT exit edge.
    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT: begin
                if (init) begin
                    state_d = S_IDLE;
                    thr_d   = umbral_starve;
                end
            end
            S_IDLE:   if (elig0 || elig1) state_d = S_ACTIVE;
            S_ACTIVE: if (!(elig0 || elig1)) state_d = S_IDLE;
            default:  state_d = S_RESET;
        endcase
    end

    // Starve counter and registered push path for the granted word.
    always_comb begin
        starve_d   = starve_q;
        d0_push_d  = 1'b0;
        d1_push_d  = 1'b0;
        data_out_d = data_out_q;
        if (grant1 || !elig1) begin
            starve_d = 4'd0;
        end else if (grant0) begin
            starve_d = starve_q + 4'd1;
        end
        if (grant0) begin
            d0_push_d  = !vc0_data[dest_bit];
            d1_push_d  = vc0_data[dest_bit];
            data_out_d = vc0_data;
        end else if (grant1) begin
            d0_push_d  = !vc1_data[dest_bit];
            d1_push_d  = vc1_data[dest_bit];
            data_out_d = vc1_data;
        end
    end

    // State registers; reset drops any in-flight push immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RESET;
            thr_q      <= '0;
            starve_q   <= '0;
            d0_push_q  <= 1'b0;
            d1_push_q  <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            starve_q   <= starve_d;
            d0_push_q  <= d0_push_d;
            d1_push_q  <= d1_push_d;
            data_out_q <= data_out_d;
        end
    end

    // Output mapping.
    always_comb begin
        vc0_pop   = grant0;
        vc1_pop   = grant1;
        d0_push   = d0_push_q;
        d1_push   = d1_push_q;
        data_out  = data_out_q;
        state_out = state_q;
    end

endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: FIFO heads come from queues, a behavioural model
// predicts every output each cycle, and directed scenarios pin key values.
module tb_vc_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic [3:0] umbral_starve = 4'd0;
    logic       vc0_empty, vc1_empty;
    logic [5:0] vc0_data, vc1_data;
    logic       d0_almost_full = 1'b0, d1_almost_full = 1'b0;
    logic       vc0_pop, vc1_pop, d0_push, d1_push;
    logic [5:0] data_out;
    logic [1:0] state_out;

    always #5 clk = ~clk;

    vc_arbiter #(.data_width(6), .dest_bit(4)) dut (
        .clk(clk), .reset(reset), .init(init), .umbral_starve(umbral_starve),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop), .d0_push(d0_push), .d1_push(d1_push),
        .data_out(data_out), .state_out(state_out)
    );

    logic [5:0] q0[$], q1[$];
    int         glog[$];
    bit         pend0, pend1;
    int         n_cmp = 0, n_bad = 0;

    // model: phase 0..3 = RESET/INIT/IDLE/ACTIVE, push 0 none / 1 D0 / 2 D1
    int         m_phase = 0, m_thr = 0, m_streak = 0, m_push = 0;
    logic [5:0] m_last = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int gl(input int i);
        return (glog.size() > i) ? glog[i] : -1;
    endfunction

    task automatic drive();
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_data  = (q0.size() != 0) ? q0[0] : 6'd0;
        vc1_data  = (q1.size() != 0) ? q1[0] : 6'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pend0 && q0.size() != 0) void'(q0.pop_front());
        if (pend1 && q1.size() != 0) void'(q1.pop_front());
        pend0 = 0;
        pend1 = 0;
        drive();
    endtask

    // Compare process: inputs are stable at the falling edge.
    bit e0, e1, srv, g0, g1;
    always @(negedge clk) begin
        pend0 = vc0_pop;
        pend1 = vc1_pop;
        if (vc0_pop) glog.push_back(0);
        if (vc1_pop) glog.push_back(1);
        if (!reset) begin
            chk("rst_state", state_out, 0);
            chk("rst_vc0_pop", vc0_pop, 0);
            chk("rst_vc1_pop", vc1_pop, 0);
            chk("rst_d0_push", d0_push, 0);
            chk("rst_d1_push", d1_push, 0);
            chk("rst_data_out", data_out, 0);
            m_phase = 0; m_thr = 0; m_streak = 0; m_push = 0; m_last = '0;
        end else begin
            e0  = !vc0_empty && !(vc0_data[4] ? d1_almost_full : d0_almost_full);
            e1  = !vc1_empty && !(vc1_data[4] ? d1_almost_full : d0_almost_full);
            srv = (m_phase >= 2);
            g1  = srv && e1 && (!e0 || (m_thr != 0 && m_streak == m_thr));
            g0  = srv && e0 && !g1;
            chk("state", state_out, m_phase);
            chk("vc0_pop", vc0_pop, g0);
            chk("vc1_pop", vc1_pop, g1);
            chk("d0_push", d0_push, m_push == 1);
            chk("d1_push", d1_push, m_push == 2);
            chk("data_out", data_out, m_last);
            m_push = 0;
            if (g0) begin m_push = vc0_data[4] ? 2 : 1; m_last = vc0_data; end
            if (g1) begin m_push = vc1_data[4] ? 2 : 1; m_last = vc1_data; end
            if (!e1 || g1) m_streak = 0;
            else if (g0) m_streak = (m_streak + 1) % 16;
            case (m_phase)
                0: m_phase = 1;
                1: if (init) begin m_phase = 2; m_thr = umbral_starve; end
                default: m_phase = (e0 || e1) ? 3 : 2;
            endcase
        end
    end

    initial begin
        drive();
        #1 reset = 1'b0;
        repeat (2) tick();
        chk("lit_reset_state", state_out, 2'b00);

        // Bring-up and a single VC0 transfer.
        umbral_starve = 4'd2;
        reset = 1'b1;
        tick();
        chk("lit_init_state", state_out, 2'b01);
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("lit_idle_state", state_out, 2'b10);
        q0.push_back(6'b000101);
        drive();
        #1 chk("lit_first_pop", vc0_pop, 1);
        tick();
        chk("lit_active_state", state_out, 2'b11);
        chk("lit_first_push", d0_push, 1);
        chk("lit_first_word", data_out, 6'b000101);
        tick();
        chk("lit_back_idle", state_out, 2'b10);
        chk("lit_hold_word", data_out, 6'b000101);

        // Starvation guard with threshold 2.
        glog.delete();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(6'd1 + 6'(i));
            q1.push_back(6'd8 + 6'(i));
        end
        drive();
        for (int k = 0; k < 40 && glog.size() < 6; k++) tick();
        chk("lit_guard_timeout", glog.size() >= 6, 1);
        chk("lit_g0", gl(0), 0); chk("lit_g1", gl(1), 0); chk("lit_g2", gl(2), 1);
        chk("lit_g3", gl(3), 0); chk("lit_g4", gl(4), 0); chk("lit_g5", gl(5), 1);
        for (int k = 0; k < 40 && (q0.size() != 0 || q1.size() != 0); k++) tick();
        chk("lit_drain_timeout", q0.size() + q1.size(), 0);
        repeat (2) tick();
        chk("lit_drain_idle", state_out, 2'b10);
        chk("lit_drain_nopush", {d0_push, d1_push}, 0);
        chk("lit_drain_hold", data_out, 6'b001101);

        // Blocked VC0 head must not stall VC1.
        d1_almost_full = 1'b1;
        q0.push_back(6'b010000);
        q1.push_back(6'b000011);
        drive();
        #1;
        chk("lit_hol_vc1_pop", vc1_pop, 1);
        chk("lit_hol_vc0_pop", vc0_pop, 0);
        tick();
        chk("lit_hol_push", d0_push, 1);
        chk("lit_hol_word", data_out, 6'b000011);
        repeat (2) tick();
        chk("lit_hol_stall", vc0_pop, 0);
        d1_almost_full = 1'b0;
        #1 chk("lit_hol_release", vc0_pop, 1);
        tick();
        chk("lit_hol_d1push", d1_push, 1);
        chk("lit_hol_d1word", data_out, 6'b010000);
        tick();

        // Guard disabled; a late init pulse must not reload the threshold.
        reset = 1'b0;
        tick();
        umbral_starve = 4'd0;
        reset = 1'b1;
        tick();
        init = 1'b1;
        tick();
        umbral_starve = 4'd1;
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(6'd4 + 6'(i));
            q1.push_back(6'd16 + 6'(i));
        end
        drive();
        for (int k = 0; k < 40 && (q0.size() != 0 || q1.size() != 0); k++) tick();
        init = 1'b0;
        chk("lit_noguard_count", glog.size(), 8);
        for (int i = 0; i < 8; i++) chk("lit_noguard_seq", gl(i), (i < 4) ? 0 : 1);
        tick();

        // Reset right after a VC1 pop kills the pending push.
        q1.push_back(6'b010110);
        drive();
        tick();
        reset = 1'b0;
        #1;
        chk("lit_rst_d1push", d1_push, 0);
        chk("lit_rst_data", data_out, 0);
        chk("lit_rst_state", state_out, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("lit_rel_state", state_out, 2'b01);
        chk("lit_rel_nopush", {d0_push, d1_push}, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
